// File: rtl/count_ones_pkg.sv
// Shared width helper and default sizing for the count_ones population counter.
package count_ones_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Bits needed to hold any count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/count_ones_popcount_tree.sv
// Combinational balanced adder tree: counts the '1' bits of din in log2 levels.
module popcount_tree
  import count_ones_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int CW         = cnt_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [CW-1:0]         count
);

  localparam int LEVELS = $clog2(DATA_WIDTH);
  localparam int PADDED = 1 << LEVELS;

  // Level 0 holds the (zero-padded) input bits; each later level halves the node count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [CW-1:0] sum [PADDED >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < PADDED; i++) begin : g_bit
        if (i < DATA_WIDTH) begin : g_real
          assign sum[i] = CW'(din[i]);
        end else begin : g_pad
          assign sum[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar j = 0; j < (PADDED >> l); j++) begin : g_node
        assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
      end
    end
  end

  assign count = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/count_ones.sv
// Registered population counter: dout/dout_valid update one clock after din is accepted.
module count_ones
  import count_ones_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int CW         = cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [CW-1:0]         dout,
  output logic                  dout_valid
);

  logic [CW-1:0] count;

  popcount_tree #(.DATA_WIDTH(DATA_WIDTH)) u_tree (
    .din   (din),
    .count (count)
  );

  // Handshake: din is accepted on any rising edge with din_valid=1 (no ready, no
  // back-pressure); dout_valid is high for exactly the cycle after an accepted word,
  // and dout keeps the last accepted count while dout_valid is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) dout <= count;
    end
  end

endmodule

// File: tb/tb_count_ones.sv
// Self-checking bench for count_ones: directed boundary/reset cases plus random words.
module tb_count_ones;
  import count_ones_pkg::*;

  parameter int DATA_WIDTH = 16;
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam int N_RANDOM = 10000;

  logic                  clk;
  logic                  resetn;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic [CW-1:0]         dout;
  logic                  dout_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_q[$];
  int last_cnt = 0;

  count_ones #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- reference model ----------------
  function automatic int ref_count(input logic [DATA_WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i < DATA_WIDTH; i++) n += (w[i] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one word on the falling edge, then check outputs just after the rising edge.
  task automatic step(input logic [255:0] w, input bit v);
    @(negedge clk);
    din       = w[DATA_WIDTH-1:0];
    din_valid = v;
    if (v) exp_q.push_back(CW'(ref_count(w[DATA_WIDTH-1:0])));
    @(posedge clk);
    #1;
    if (v) last_cnt = int'(exp_q.pop_front());
    check("dout", int'(dout), last_cnt);
    check("dout_valid", int'(dout_valid), int'(v));
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    case ($urandom_range(0, 15))
      0: w = '0;
      1: w = '1;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    resetn    = 1'b1;
    din       = '0;
    din_valid = 1'b0;

    // Load a nonzero result so the asynchronous clear is observable.
    step({256{1'b1}}, 1'b1);
    check("preload_all_ones", int'(dout), DATA_WIDTH);

    // Asynchronous reset with din=all-ones, din_valid=1, no clock edge.
    @(negedge clk);
    din       = '1;
    din_valid = 1'b1;
    resetn    = 1'b0;
    #1;
    check("rst_async_dout", int'(dout), 0);
    check("rst_async_valid", int'(dout_valid), 0);
    @(posedge clk);
    #1;
    check("rst_held_dout", int'(dout), 0);
    check("rst_held_valid", int'(dout_valid), 0);
    exp_q.delete();
    last_cnt = 0;
    @(negedge clk);
    din_valid = 1'b0;
    resetn    = 1'b1;

    // Sequence 3,5,8 then boundaries.
    step(256'd3, 1'b1);
    step(256'd5, 1'b1);
    step(256'd8, 1'b1);
    step(256'h0000, 1'b1);
    step({256{1'b1}}, 1'b1);
    check("all_ones_is_width", int'(dout), DATA_WIDTH);
    step(256'h8001, 1'b1);

    // Valid gating: dout holds, dout_valid drops.
    step(256'h00FF, 1'b0);
    step(256'h00FF, 1'b1);
    step(256'h1234, 1'b0);

    // Reset mid-stream between two valid words.
    step(256'h0F0F, 1'b1);
    @(negedge clk);
    din       = 16'hFFFF;
    din_valid = 1'b1;
    resetn    = 1'b0;
    #1;
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    exp_q.delete();
    last_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;
    din_valid = 1'b0;
    step(256'h0007, 1'b1);
    step(256'h0000, 1'b0);

    // Random words, mostly valid.
    for (int n = 0; n < N_RANDOM; n++) begin
      step(rand_word(), $urandom_range(0, 7) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
